// File: rtl/ddr3_init_engine.sv
// DDR3 power-up sequencer: RESET#/CKE timing, MRS to MR2/MR3/MR1/MR0, then ZQCL.
// Commands leave over a valid/ready handshake; every output is registered from the next state.
module ddr3_init_engine #(
    parameter int          T_RST    = 200,
    parameter int          T_CKE    = 500,
    parameter int          T_XPR    = 5,
    parameter int          T_MRD    = 4,
    parameter int          T_MOD    = 12,
    parameter int          T_ZQINIT = 512,
    parameter logic [13:0] MR0_VAL  = 14'h0520,
    parameter logic [13:0] MR1_VAL  = 14'h0004,
    parameter logic [13:0] MR2_VAL  = 14'h0008,
    parameter logic [13:0] MR3_VAL  = 14'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init_start,
    output logic        o_init_done,
    output logic        o_init_busy,
    output logic        o_ddr_reset_n,
    output logic        o_ddr_cke,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [2:0]  o_cmd,
    output logic [2:0]  o_cmd_ba,
    output logic [13:0] o_cmd_addr,
    output logic [3:0]  o_state
);

    typedef enum logic [3:0] {
        IDLE, RST_HOLD, CKE_WAIT, XPR_WAIT, MRS2, W2, MRS3, W3,
        MRS1, W1, MRS0, W0, ZQCL, WZQ, DONE
    } state_t;

    localparam logic [2:0] CMD_MRS  = 3'b000;
    localparam logic [2:0] CMD_ZQCL = 3'b110;
    localparam logic [2:0] CMD_NOP  = 3'b111;

    localparam logic [CNT_W-1:0] L_RST = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] L_CKE = CNT_W'(T_CKE - 1);
    localparam logic [CNT_W-1:0] L_XPR = CNT_W'(T_XPR - 1);
    localparam logic [CNT_W-1:0] L_MRD = CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0] L_MOD = CNT_W'(T_MOD - 1);
    localparam logic [CNT_W-1:0] L_ZQ  = CNT_W'(T_ZQINIT - 1);

    state_t             r_state, w_next_state;
    logic [CNT_W-1:0]   r_timer, w_next_timer;
    logic               w_tmr_zero, w_xfer;
    logic               w_reset_n, w_cke, w_valid, w_done, w_busy;
    logic [2:0]         w_cmd, w_ba;
    logic [13:0]        w_addr;

    assign w_tmr_zero = (r_timer == '0);
    assign w_xfer     = o_cmd_valid & i_cmd_ready;

    // Timer counts down to zero and parks there; transitions reload it for the next wait.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = w_tmr_zero ? '0 : r_timer - 1'b1;
        case (r_state)
            IDLE:     if (i_init_start) begin w_next_state = RST_HOLD; w_next_timer = L_RST; end
            RST_HOLD: if (w_tmr_zero)   begin w_next_state = CKE_WAIT; w_next_timer = L_CKE; end
            CKE_WAIT: if (w_tmr_zero)   begin w_next_state = XPR_WAIT; w_next_timer = L_XPR; end
            XPR_WAIT: if (w_tmr_zero)   w_next_state = MRS2;
            MRS2:     if (w_xfer)       begin w_next_state = W2; w_next_timer = L_MRD; end
            W2:       if (w_tmr_zero)   w_next_state = MRS3;
            MRS3:     if (w_xfer)       begin w_next_state = W3; w_next_timer = L_MRD; end
            W3:       if (w_tmr_zero)   w_next_state = MRS1;
            MRS1:     if (w_xfer)       begin w_next_state = W1; w_next_timer = L_MRD; end
            W1:       if (w_tmr_zero)   w_next_state = MRS0;
            MRS0:     if (w_xfer)       begin w_next_state = W0; w_next_timer = L_MOD; end
            W0:       if (w_tmr_zero)   w_next_state = ZQCL;
            ZQCL:     if (w_xfer)       begin w_next_state = WZQ; w_next_timer = L_ZQ; end
            WZQ:      if (w_tmr_zero)   w_next_state = DONE;
            DONE:     w_next_state = DONE;
            default:  w_next_state = IDLE;
        endcase
    end

    // Output values for the state being entered, so registered outputs line up with r_state.
    always_comb begin
        w_reset_n = !(w_next_state == IDLE || w_next_state == RST_HOLD);
        w_cke     = !(w_next_state == IDLE || w_next_state == RST_HOLD ||
                      w_next_state == CKE_WAIT);
        w_done    = (w_next_state == DONE);
        w_busy    = (w_next_state != IDLE) && (w_next_state != DONE);
        w_valid   = 1'b0;
        w_cmd     = CMD_NOP;
        w_ba      = 3'd0;
        w_addr    = 14'd0;
        case (w_next_state)
            MRS2: begin w_valid = 1'b1; w_cmd = CMD_MRS;  w_ba = 3'd2; w_addr = MR2_VAL; end
            MRS3: begin w_valid = 1'b1; w_cmd = CMD_MRS;  w_ba = 3'd3; w_addr = MR3_VAL; end
            MRS1: begin w_valid = 1'b1; w_cmd = CMD_MRS;  w_ba = 3'd1; w_addr = MR1_VAL; end
            MRS0: begin w_valid = 1'b1; w_cmd = CMD_MRS;  w_ba = 3'd0; w_addr = MR0_VAL; end
            ZQCL: begin w_valid = 1'b1; w_cmd = CMD_ZQCL; w_ba = 3'd0; w_addr = 14'h0400; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            o_init_done   <= 1'b0;
            o_init_busy   <= 1'b0;
            o_ddr_reset_n <= 1'b0;
            o_ddr_cke     <= 1'b0;
            o_cmd_valid   <= 1'b0;
            o_cmd         <= CMD_NOP;
            o_cmd_ba      <= 3'd0;
            o_cmd_addr    <= 14'd0;
        end else begin
            r_state       <= w_next_state;
            r_timer       <= w_next_timer;
            o_init_done   <= w_done;
            o_init_busy   <= w_busy;
            o_ddr_reset_n <= w_reset_n;
            o_ddr_cke     <= w_cke;
            o_cmd_valid   <= w_valid;
            o_cmd         <= w_cmd;
            o_cmd_ba      <= w_ba;
            o_cmd_addr    <= w_addr;
        end
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_ddr3_init_engine.sv
// Directed bench for ddr3_init_engine: a table of cycle checkpoints plus hand sequences
// for command back-pressure and reset in the middle of a command.
module tb_ddr3_init_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_start, cmd_ready;
    logic        init_done, init_busy, ddr_reset_n, ddr_cke, cmd_valid;
    logic [2:0]  cmd, cmd_ba;
    logic [13:0] cmd_addr;
    logic [3:0]  state;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int xfer_cnt;
    logic [19:0] exp_q[$];

    ddr3_init_engine dut (
        .clk(clk), .rst(rst), .i_init_start(init_start), .o_init_done(init_done),
        .o_init_busy(init_busy), .o_ddr_reset_n(ddr_reset_n), .o_ddr_cke(ddr_cke),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd(cmd), .o_cmd_ba(cmd_ba),
        .o_cmd_addr(cmd_addr), .o_state(state)
    );

    // clock / reset / cycle counter: cycle N is the interval that posedge N opens
    always #5 clk = ~clk;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // scoreboard: each handshake must match the next expected {cmd, ba, addr}
    always @(negedge clk) begin
        #2;
        if (!rst && cmd_valid && cmd_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) check("xfer_unexpected", {12'd0, cmd, cmd_ba, cmd_addr}, 32'hFFFFF);
            else check("xfer_fields", {12'd0, cmd, cmd_ba, cmd_addr}, {12'd0, exp_q.pop_front()});
        end
    end

    typedef struct {
        int         cyc;
        logic       start;
        logic [24:0] exp;
    } vec_t;
    vec_t tbl[24];

    function automatic logic [24:0] ov(input logic rn, input logic ck, input logic v,
                                       input logic [2:0] c, input logic [2:0] ba,
                                       input logic [13:0] a, input logic d, input logic b);
        return {rn, ck, v, c, ba, a, d, b};
    endfunction

    function automatic logic [24:0] act_vec();
        return {ddr_reset_n, ddr_cke, cmd_valid, cmd, cmd_ba, cmd_addr, init_done, init_busy};
    endfunction

    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        init_start = 1'b0;
        cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        xfer_cnt = 0;
    endtask

    task automatic push_all();
        exp_q.push_back({3'b000, 3'd2, 14'h0008});
        exp_q.push_back({3'b000, 3'd3, 14'h0000});
        exp_q.push_back({3'b000, 3'd1, 14'h0004});
        exp_q.push_back({3'b000, 3'd0, 14'h0520});
        exp_q.push_back({3'b110, 3'd0, 14'h0400});
    endtask

    task automatic run_table(input string tag);
        push_all();
        for (int i = 0; i < 24; i++) begin
            wait_cycle(tbl[i].cyc);
            check($sformatf("%s_c%0d", tag, tbl[i].cyc), {7'd0, act_vec()}, {7'd0, tbl[i].exp});
            if (tbl[i].start) begin
                init_start = 1'b1;
                @(negedge clk);
                init_start = 1'b0;
            end
        end
        check({tag, "_xfer_count"}, xfer_cnt, 5);
        check({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [24:0] idle_o, rst_o, cke0_o, cke1_o, done_o;
        idle_o = ov(0, 0, 0, 3'b111, 0, 14'h0, 0, 0);
        rst_o  = ov(0, 0, 0, 3'b111, 0, 14'h0, 0, 1);
        cke0_o = ov(1, 0, 0, 3'b111, 0, 14'h0, 0, 1);
        cke1_o = ov(1, 1, 0, 3'b111, 0, 14'h0, 0, 1);
        done_o = ov(1, 1, 0, 3'b111, 0, 14'h0, 1, 0);
        tbl[0]  = '{5,    0, idle_o};
        tbl[1]  = '{10,   1, idle_o};
        tbl[2]  = '{11,   0, rst_o};
        tbl[3]  = '{210,  0, rst_o};
        tbl[4]  = '{211,  0, cke0_o};
        tbl[5]  = '{300,  1, cke0_o};
        tbl[6]  = '{301,  0, cke0_o};
        tbl[7]  = '{710,  0, cke0_o};
        tbl[8]  = '{711,  0, cke1_o};
        tbl[9]  = '{715,  0, cke1_o};
        tbl[10] = '{716,  0, ov(1, 1, 1, 3'b000, 3'd2, 14'h0008, 0, 1)};
        tbl[11] = '{717,  0, cke1_o};
        tbl[12] = '{720,  0, cke1_o};
        tbl[13] = '{721,  0, ov(1, 1, 1, 3'b000, 3'd3, 14'h0000, 0, 1)};
        tbl[14] = '{726,  0, ov(1, 1, 1, 3'b000, 3'd1, 14'h0004, 0, 1)};
        tbl[15] = '{731,  0, ov(1, 1, 1, 3'b000, 3'd0, 14'h0520, 0, 1)};
        tbl[16] = '{735,  1, cke1_o};
        tbl[17] = '{743,  0, cke1_o};
        tbl[18] = '{744,  0, ov(1, 1, 1, 3'b110, 3'd0, 14'h0400, 0, 1)};
        tbl[19] = '{745,  0, cke1_o};
        tbl[20] = '{1256, 0, cke1_o};
        tbl[21] = '{1257, 0, done_o};
        tbl[22] = '{1500, 1, done_o};
        tbl[23] = '{1600, 0, done_o};

        // run A: ready tied high, start pulses in CKE_WAIT, W0 and DONE are ignored
        do_reset();
        check("reset_outputs", {7'd0, act_vec()}, {7'd0, idle_o});
        check("reset_state", {28'd0, state}, 32'd0);
        run_table("runA");

        // run B: back-pressure on MRS1 for 7 cycles
        do_reset();
        push_all();
        wait_cycle(10);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_cycle(726);
        cmd_ready = 1'b0;
        for (int c = 726; c <= 733; c++) begin
            wait_cycle(c);
            check($sformatf("runB_hold_c%0d", c), {12'd0, cmd_valid, cmd, cmd_ba, cmd_addr},
                  {12'd0, 1'b1, 3'b000, 3'd1, 14'h0004});
            if (c == 733) cmd_ready = 1'b1;
        end
        wait_cycle(734);
        check("runB_w1_start", {31'd0, cmd_valid}, 32'd0);
        wait_cycle(737);
        check("runB_w1_end", {31'd0, cmd_valid}, 32'd0);
        wait_cycle(738);
        check("runB_mrs0", {12'd0, cmd_valid, cmd, cmd_ba, cmd_addr},
              {12'd0, 1'b1, 3'b000, 3'd0, 14'h0520});
        wait_cycle(1263);
        check("runB_pre_done", {30'd0, init_done, init_busy}, 32'd1);
        wait_cycle(1264);
        check("runB_done", {30'd0, init_done, init_busy}, 32'd2);
        check("runB_xfer_count", xfer_cnt, 5);
        check("runB_queue_left", exp_q.size(), 0);

        // run C: reset while MRS3 is presented and stalled
        do_reset();
        push_all();
        wait_cycle(10);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_cycle(720);
        cmd_ready = 1'b0;
        wait_cycle(721);
        check("runC_mrs3", {12'd0, cmd_valid, cmd, cmd_ba, cmd_addr},
              {12'd0, 1'b1, 3'b000, 3'd3, 14'h0000});
        check("runC_one_xfer", xfer_cnt, 1);
        #1 rst = 1'b1;
        #1;
        check("runC_async_reset", {7'd0, act_vec()}, {7'd0, idle_o});
        check("runC_reset_state", {28'd0, state}, 32'd0);

        // run D: the full sequence replays after reset
        do_reset();
        run_table("runD");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
